// File: rtl/wb_lock_scheduler.sv
// Register-lock scoreboard and writeback scheduler: counts outstanding writers per register,
// arbitrates execution-unit writebacks round-robin onto one register-file port, releases locks on commit.
module wb_lock_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WB   = 4,
  parameter int XLEN     = 64,
  parameter int CNT_W    = 2,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int PW      = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clear_i,
  input  logic                   launch_i,
  input  logic [AW-1:0]          launch_rd_i,
  output logic                   launch_ready_o,
  output logic [NUM_REGS-1:0]    locks_o,
  input  logic [NUM_WB-1:0]      wb_valid_i,
  input  logic [NUM_WB*AW-1:0]   wb_rd_i,
  input  logic [NUM_WB*XLEN-1:0] wb_data_i,
  output logic [NUM_WB-1:0]      wb_ready_o,
  output logic                   rf_we_o,
  output logic [AW-1:0]          rf_waddr_o,
  output logic [XLEN-1:0]        rf_wdata_o,
  output logic                   underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             underflow_q, underflow_d;

  logic             grant_v;
  logic [PW-1:0]    grant_idx;
  logic [AW-1:0]    grant_rd;
  logic [XLEN-1:0]  grant_data;
  logic             launch_acc;
  logic             inc, dec;

  assign launch_ready_o = (launch_rd_i == '0) || (cnt_q[launch_rd_i] != CNT_MAX);
  assign launch_acc     = launch_i && launch_ready_o && (launch_rd_i != '0) && !clear_i;

  always_comb begin
    locks_o = '0;
    for (int r = 1; r < NUM_REGS; r++) locks_o[r] = (cnt_q[r] != '0);
  end

  // Round-robin scan starting at ptr_q; no grant while flushing or in reset.
  always_comb begin : arb
    int idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_v    = 1'b0;
    grant_idx  = '0;
    grant_rd   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_WB) idx = idx - NUM_WB;
      if (!grant_v && wb_valid_i[PW'(idx)]) begin
        grant_v   = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (arst_i || clear_i) grant_v = 1'b0;
    for (int u = 0; u < NUM_WB; u++) begin
      if (grant_idx == PW'(u)) begin
        grant_rd   = wb_rd_i[u*AW +: AW];
        grant_data = wb_data_i[u*XLEN +: XLEN];
      end
    end
  end

  assign wb_ready_o = grant_v ? (NUM_WB'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    underflow_d = underflow_q;
    cnt_d       = cnt_q;
    inc         = 1'b0;
    dec         = 1'b0;
    if (clear_i) begin
      ptr_d       = '0;
      underflow_d = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
    end else begin
      if (grant_v) begin
        ptr_d      = (grant_idx == PW'(NUM_WB - 1)) ? '0 : grant_idx + 1'b1;
        rf_we_d    = (grant_rd != '0);
        rf_waddr_d = grant_rd;
        rf_wdata_d = grant_data;
      end
      // A launch and a commit to the same register on one edge cancel out.
      for (int r = 1; r < NUM_REGS; r++) begin
        inc = launch_acc && (launch_rd_i == AW'(r));
        dec = rf_we_q && (rf_waddr_q == AW'(r));
        if (dec && (cnt_q[r] == '0)) underflow_d = 1'b1;
        if (inc && !dec) cnt_d[r] = cnt_q[r] + 1'b1;
        else if (dec && !inc && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - 1'b1;
      end
      cnt_d[0] = '0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      underflow_q <= 1'b0;
      // NOTE: the count array is a small flop bank, not a RAM macro, so it is reset like any register.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_wb_lock_scheduler.sv
// Scoreboard bench for wb_lock_scheduler: directed scenarios plus random traffic against a
// count-array reference model; a monitor pops expected register-file writes as the DUT commits them.
module tb_wb_lock_scheduler;
  localparam int NUM_REGS = 32;
  localparam int NUM_WB   = 4;
  localparam int XLEN     = 64;
  localparam int CNT_W    = 2;
  localparam int AW       = $clog2(NUM_REGS);
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   arst_i = 1'b1;
  logic                   clear_i = 1'b0;
  logic                   launch_i = 1'b0;
  logic [AW-1:0]          launch_rd_i = '0;
  logic                   launch_ready_o;
  logic [NUM_REGS-1:0]    locks_o;
  logic [NUM_WB-1:0]      wb_valid_i = '0;
  logic [NUM_WB*AW-1:0]   wb_rd_i = '0;
  logic [NUM_WB*XLEN-1:0] wb_data_i = '0;
  logic [NUM_WB-1:0]      wb_ready_o;
  logic                   rf_we_o;
  logic [AW-1:0]          rf_waddr_o;
  logic [XLEN-1:0]        rf_wdata_o;
  logic                   underflow_o;

  wb_lock_scheduler #(.NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .arst_i(arst_i), .clear_i(clear_i), .launch_i(launch_i),
    .launch_rd_i(launch_rd_i), .launch_ready_o(launch_ready_o), .locks_o(locks_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              cyc = 0;
  bit              mon_en = 1'b0;

  // Reference model state
  int              cnt[NUM_REGS];
  int              ptr;
  bit              uf;
  bit              commit_v;
  int              commit_rd;
  int              pool[$];
  bit              pend[NUM_WB];
  logic [AW-1:0]   pend_rd[NUM_WB];
  logic [XLEN-1:0] pend_data[NUM_WB];
  bit              drv_launch, drv_clear;
  logic [AW-1:0]   drv_rd;
  logic [NUM_WB-1:0] obs_gnt;
  logic            obs_lr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    launch_i    = drv_launch;
    launch_rd_i = drv_rd;
    clear_i     = drv_clear;
    for (int u = 0; u < NUM_WB; u++) begin
      wb_valid_i[u]              = pend[u];
      wb_rd_i[u*AW +: AW]        = pend_rd[u];
      wb_data_i[u*XLEN +: XLEN]  = pend_data[u];
    end
  endtask

  task automatic req(input int u, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    pend[u] = 1'b1; pend_rd[u] = rd; pend_data[u] = d;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) cnt[r] = 0;
    ptr = 0; uf = 0; commit_v = 0; commit_rd = 0;
    for (int u = 0; u < NUM_WB; u++) pend[u] = 0;
    pool.delete();
    exp_q.delete();
  endtask

  // One clock: drive at negedge, compare combinational outputs, then advance the model to the next edge.
  task automatic cycle();
    logic [NUM_REGS-1:0] exp_locks;
    bit lr, acc;
    int g;
    @(negedge clk);
    apply();
    #1;
    exp_locks = '0;
    for (int r = 0; r < NUM_REGS; r++) exp_locks[r] = (cnt[r] != 0);
    lr = (drv_rd == 0) || (cnt[drv_rd] != MAXC);
    g = -1;
    if (!drv_clear)
      for (int i = 0; i < NUM_WB; i++)
        if (g < 0 && pend[(ptr + i) % NUM_WB]) g = (ptr + i) % NUM_WB;
    check("locks_o", locks_o, exp_locks);
    check("launch_ready_o", launch_ready_o, lr);
    check("wb_ready_o", wb_ready_o, (g < 0) ? 64'd0 : (64'd1 << g));
    check("underflow_o", underflow_o, uf);
    obs_gnt = wb_ready_o;
    obs_lr  = launch_ready_o;
    if (drv_clear) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] = 0;
      ptr = 0; uf = 0; commit_v = 0;
      for (int u = 0; u < NUM_WB; u++) pend[u] = 0;
      pool.delete();
    end else begin
      acc = drv_launch && lr && (drv_rd != 0);
      if (commit_v) begin
        if (cnt[commit_rd] == 0) uf = 1;
        cnt[commit_rd] -= 1;
      end
      if (acc) begin
        cnt[drv_rd] += 1;
        pool.push_back(int'(drv_rd));
      end
      for (int r = 0; r < NUM_REGS; r++) if (cnt[r] < 0) cnt[r] = 0;
      if (g >= 0) begin
        ptr       = (g + 1) % NUM_WB;
        commit_v  = (pend_rd[g] != 0);
        commit_rd = int'(pend_rd[g]);
        if (commit_v) exp_q.push_back('{cyc + 1, pend_rd[g], pend_data[g]});
        pend[g] = 0;
      end else begin
        commit_v = 0;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic rand_stim(input bit allow_clear);
    int k;
    drv_clear  = allow_clear && ($urandom_range(0, 99) < 2);
    drv_launch = $urandom_range(0, 99) < 60;
    drv_rd     = AW'($urandom_range(0, 9));
    for (int u = 0; u < NUM_WB; u++) begin
      if (!pend[u] && $urandom_range(0, 99) < 40) begin
        if (pool.size() > 0) begin
          k = $urandom_range(0, pool.size() - 1);
          req(u, AW'(pool[k]), {$urandom, $urandom});
          pool.delete(k);
        end else if ($urandom_range(0, 99) < 10) begin
          req(u, AW'($urandom_range(0, NUM_REGS - 1)), {$urandom, $urandom});
        end
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    arst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_launch = $urandom_range(0, 1);
      drv_rd     = AW'($urandom_range(0, NUM_REGS - 1));
      drv_clear  = $urandom_range(0, 1);
      for (int u = 0; u < NUM_WB; u++) begin
        pend[u] = $urandom_range(0, 1); pend_rd[u] = AW'($urandom); pend_data[u] = {$urandom, $urandom};
      end
      apply();
      #3;
      check("rst_locks_o", locks_o, 0);
      check("rst_rf_we_o", rf_we_o, 0);
      check("rst_wb_ready_o", wb_ready_o, 0);
      check("rst_launch_ready_o", launch_ready_o, 1);
      check("rst_underflow_o", underflow_o, 0);
    end
    model_reset();
    drv_launch = 0; drv_clear = 0; drv_rd = '0;
    @(negedge clk);
    apply();
    arst_i = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: every committed write must match the oldest expected one, on the expected cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rf_we_o) begin
          if (exp_q.size() == 0) begin
            check("rf_we_o_spurious", rf_we_o, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_cycle", cyc, e.cyc);
            check("rf_waddr_o", rf_waddr_o, e.rd);
            check("rf_wdata_o", rf_wdata_o, e.data);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check("rf_we_o_missing", rf_we_o, 1);
          e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [NUM_WB-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    model_reset();
    drv_launch = 0; drv_clear = 0; drv_rd = '0;
    do_reset();

    // Launch, writeback, lock release timing
    drv_launch = 1; drv_rd = 5; cycle(); drv_launch = 0;
    #1 check("t1_lock5_set", locks_o[5], 1);
    cycle(); cycle();
    req(2, 5, 64'hABCD); cycle();
    check("t1_grant", obs_gnt, 4'b0100);
    #1 check("t1_rf_we", rf_we_o, 1);
    check("t1_lock5_during_write", locks_o[5], 1);
    cycle();
    #1 check("t1_lock5_released", locks_o[5], 0);

    // Round robin from a cleared pointer
    drv_clear = 1; cycle(); drv_clear = 0;
    foreach (rr_exp[i]) begin
      drv_launch = 1; drv_rd = (i == 0) ? AW'(1) : AW'(i); cycle();
    end
    drv_launch = 0;
    for (int u = 0; u < NUM_WB; u++) req(u, AW'(u + 1), {$urandom, $urandom});
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_grant", obs_gnt, rr_exp[i]);
      if (i == 0) req(0, 1, {$urandom, $urandom});
    end
    cycle(); cycle();

    // Counter saturation on r7
    drv_launch = 1; drv_rd = 7;
    repeat (3) cycle();
    cycle();
    check("sat_not_ready", obs_lr, 0);
    drv_launch = 0;
    req(1, 7, {$urandom, $urandom});
    cycle(); cycle(); cycle();
    check("sat_ready_after_commit", obs_lr, 1);
    #1 check("sat_lock7_held", locks_o[7], 1);

    // Commit and launch to r9 on the same edge; then r0 traffic
    drv_launch = 1; drv_rd = 9; cycle(); drv_launch = 0;
    req(0, 9, {$urandom, $urandom}); cycle();
    drv_launch = 1; drv_rd = 9; cycle(); drv_launch = 0;
    #1 check("sim_lock9_after_edge", locks_o[9], 1);
    cycle();
    #1 check("sim_lock9_held", locks_o[9], 1);
    drv_launch = 1; drv_rd = 0; req(3, 0, {$urandom, $urandom}); cycle(); drv_launch = 0;
    check("r0_launch_ready", obs_lr, 1);
    #1 check("r0_not_locked", locks_o[0], 0);
    check("r0_no_rf_we", rf_we_o, 0);

    // Underflow on unlocked r3, then clear
    req(2, 3, {$urandom, $urandom}); cycle(); cycle();
    #1 check("uf_set", underflow_o, 1);
    drv_clear = 1; cycle(); drv_clear = 0;
    #1 check("clr_underflow", underflow_o, 0);
    check("clr_locks", locks_o, 0);
    req(2, 0, {$urandom, $urandom}); req(0, 0, {$urandom, $urandom}); cycle();
    check("clr_ptr_restart", obs_gnt, 4'b0001);
    cycle();

    // Random traffic
    drv_clear = 1; cycle(); drv_clear = 0; pool.delete();
    repeat (1500) begin rand_stim(1'b1); cycle(); end

    // Reset while a register-file write is pending
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      rand_stim(1'b0); cycle();
      found = (exp_q.size() > 0);
    end
    check("midrst_write_pending", found, 1);
    if (found) begin
      #1 check("midrst_rf_we_before", rf_we_o, 1);
      mon_en = 0;
      arst_i = 1'b1;
      #1 check("midrst_rf_we_dropped", rf_we_o, 0);
      check("midrst_locks", locks_o, 0);
    end
    do_reset();
    repeat (500) begin rand_stim(1'b1); cycle(); end

    // Drain outstanding requests
    drv_launch = 0; drv_clear = 0;
    repeat (2 * NUM_WB + 2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_lock_scheduler.md
Name: wb_lock_scheduler

Overview:
Register-lock scoreboard and writeback scheduler that feeds the instruction launcher's locks_i input. Increments a per-register outstanding-writer count on every launch and arbitrates NUM_WB execution-unit writeback requesters round-robin onto the single register-file write port. Releases the lock on the cycle the register file actually commits the write. Sits between the launcher, the execution units and the register file.

Parameters:
NUM_REGS, 32, architectural registers; lock vector width.
NUM_WB, 4, writeback requesters (execution units).
XLEN, 64, writeback data width.
CNT_W, 2, outstanding-writer counter width per register; max count 2**CNT_W-1.

Ports:
clk_i  in  1  clock, rising edge.
arst_i  in  1  asynchronous reset, active-high.
clear_i  in  1  synchronous flush of all state.
launch_i  in  1  instruction handed to execution this cycle (launcher valid&ready).
launch_rd_i  in  $clog2(NUM_REGS)  destination of launched instruction.
launch_ready_o  out  1  launch_rd_i counter not saturated; gates launcher output ready.
locks_o  out  NUM_REGS  bit r = count[r]!=0; drives launcher locks_i.
wb_valid_i  in  NUM_WB  writeback request per unit.
wb_rd_i  in  NUM_WB*$clog2(NUM_REGS)  packed destination per unit.
wb_data_i  in  NUM_WB*XLEN  packed data per unit.
wb_ready_o  out  NUM_WB  one-hot grant; at most one bit set.
rf_we_o  out  1  register-file write enable (registered).
rf_waddr_o  out  $clog2(NUM_REGS)  write address (registered).
rf_wdata_o  out  XLEN  write data (registered).
underflow_o  out  1  sticky: writeback granted to register with count 0.

Behaviour:
- Reset (arst_i high, async): all counts 0, rr pointer 0, rf_we_o/rf_waddr_o/rf_wdata_o 0, underflow_o 0. locks_o=0, launch_ready_o=1, wb_ready_o=0 while reset asserted.
- Register 0: never locked, count[0] fixed 0; launch to r0 always ready, no count change; writeback to r0 granted normally but rf_we_o stays 0 for it, no underflow.
- launch_ready_o combinational: 1 if launch_rd_i==0 or count[launch_rd_i]!=max. launch_i with launch_ready_o=0 is ignored (no increment).
- Arbitration (combinational): scan wb_valid_i starting at index ptr, wrapping; first valid gets wb_ready_o. Handshake = valid&ready. After a grant, ptr <= granted+1 mod NUM_WB; no grant -> ptr unchanged. Units hold valid/rd/data stable until granted.
- Grant at edge E0 -> rf_we_o=1, rf_waddr_o, rf_wdata_o registered at E0 (1-cycle latency); register file writes at E1. No grant -> rf_we_o=0 next cycle, addr/data hold.
- Lock release: count[rf_waddr_o] decrements at E1 (edge where rf_we_o is high), so locks_o falls the cycle after rf_we_o, never before the write is visible.
- Count update per register per edge: +1 for accepted launch, -1 for committing rf_we_o; both on same register -> unchanged. Saturation prevented by launch_ready_o.
- Decrement on count 0 (rf_we_o committing to unlocked reg): count stays 0, underflow_o set and held until reset/clear.
- clear_i (sync, priority over all updates): counts 0, ptr 0, rf_we_o 0, underflow_o 0 at next edge; wb_ready_o forced 0 during clear cycle; launch_i ignored that cycle.
- Reset mid-operation: pending rf write is discarded (rf_we_o 0 immediately).

Test Plan:
- Reset: arst_i=1 with random inputs -> locks_o=0, rf_we_o=0, wb_ready_o=0, launch_ready_o=1; release -> same values, first cycle idle.
- Launch rd=5 at E0, wb unit2 rd=5 data=0xABCD at E3 -> locks_o[5]=1 from E0+; wb_ready_o=0b0100 at E3; rf_we_o=1, waddr=5, wdata=0xABCD after E3; locks_o[5]=0 after E4.
- Round robin: wb_valid_i=0b1111 held, rd 1..4 pre-launched -> grants 0b0001,0b0010,0b0100,0b1000,0b0001 on successive cycles.
- Saturation: CNT_W=2, three launches to rd=7 -> launch_ready_o=0 for rd=7; fourth launch_i ignored; one commit -> launch_ready_o=1, locks_o[7] still 1.
- Simultaneous: count[9]=1, commit to r9 and launch rd=9 same edge -> count[9]=1, locks_o[9] stays 1; r0 launch/writeback -> locks_o[0]=0, rf_we_o=0.
- Underflow and clear: writeback to unlocked r3 -> underflow_o=1 after commit; clear_i pulse -> underflow_o=0, all locks 0, ptr restarts at unit 0.
